charmap_scroll: RTL

- Parametrised, fully pipelined successor to the character-map renderer.
- Turns raster counters into tile-map, glyph-ROM and palette reads, with per-pixel hardware scrolling that wraps.
- Scroll offsets are latched once per frame, and a display-enable flag travels through the pipeline alongside the pixel.
- Sits between the video timing generator and the layer mixer, and drives the chram, colour RAM, glyph ROM and palette RAM read ports.

---
 rtl/charmap_scroll.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/charmap_scroll.sv
// ---------------------------------------------------------------------------
// charmap_scroll
//
// Pipelined character-map renderer with wrapping per-pixel hardware scroll.
// Raster counters are offset by the active scroll registers, turned into a
// tile-map read, then a glyph-ROM read, then a palette read, and finally
// registered onto the colour outputs. A display-enable flag travels through
// the pipeline alongside each pixel.
//
// Optional feature (compile-time macro CHARMAP_FADE_EN):
//   adds a 4-bit 'fade' input and a final scaling stage,
//   c_out = (c * fade) >> 4, with fade = 4'hF passing c unchanged.
//   Pixel latency grows from 4 to 5 ce_pix pulses.
//
// Ports:
//   clk                      pixel-domain clock
//   reset                    asynchronous, active-low reset
//   ce_pix                   pixel clock enable; pipeline advances when 1
//   hcnt, vcnt               raster x / y
//   de                       display enable aligned with hcnt/vcnt
//   vblank                   vertical blank; rising edge latches scroll
//   scroll_x, scroll_y       requested pixel offsets
//   fade                     (CHARMAP_FADE_EN only) brightness, 4'hF = full
//   chmap_data_out           glyph index read from chram
//   fgcolram_data_out        foreground palette index
//   bgcolram_data_out        background palette index
//   chrom_data_out           glyph row bits, MSB = leftmost pixel
//   charpaletteram_data_out  palette entry {b,g,r}
//   chram_addr               {row,col}, shared by chram and both colour RAMs
//   chrom_addr               {glyph,row}
//   charpaletteram_addr_rd   palette read address
//   r, g, b, a               pixel colour and opacity
//   de_out                   display enable aligned with r/g/b/a
//
// All memories are expected to have exactly one clk of read latency; the
// addresses driven here are held between ce_pix pulses.
// ---------------------------------------------------------------------------
module charmap_scroll #(
    parameter int          CHAR_W_LOG2    = 3,
    parameter int          CHAR_H_LOG2    = 3,
    parameter int          MAP_COLS_LOG2  = 6,
    parameter int          MAP_ROWS_LOG2  = 6,
    parameter int          GLYPHS_LOG2    = 8,
    parameter int          CNT_W          = 9,
    parameter logic [7:0]  TRANSPARENT_BG = 8'hC7
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   ce_pix,
    input  logic [CNT_W-1:0]                       hcnt,
    input  logic [CNT_W-1:0]                       vcnt,
    input  logic                                   de,
    input  logic                                   vblank,
    input  logic [CNT_W-1:0]                       scroll_x,
    input  logic [CNT_W-1:0]                       scroll_y,
`ifdef CHARMAP_FADE_EN
    input  logic [3:0]                             fade,
`endif
    input  logic [GLYPHS_LOG2-1:0]                 chmap_data_out,
    input  logic [7:0]                             fgcolram_data_out,
    input  logic [7:0]                             bgcolram_data_out,
    input  logic [(1<<CHAR_W_LOG2)-1:0]            chrom_data_out,
    input  logic [23:0]                            charpaletteram_data_out,
    output logic [MAP_ROWS_LOG2+MAP_COLS_LOG2-1:0] chram_addr,
    output logic [GLYPHS_LOG2+CHAR_H_LOG2-1:0]     chrom_addr,
    output logic [7:0]                             charpaletteram_addr_rd,
    output logic [7:0]                             r,
    output logic [7:0]                             g,
    output logic [7:0]                             b,
    output logic                                   a,
    output logic                                   de_out
);

    // Scrolled coordinate widths: one full tile map in pixels.
    localparam int SX_W = MAP_COLS_LOG2 + CHAR_W_LOG2;
    localparam int SY_W = MAP_ROWS_LOG2 + CHAR_H_LOG2;

    localparam logic [CHAR_W_LOG2-1:0] BIT_MSB = '1;

    // -----------------------------------------------------------------------
    // Scroll latch: captured on the vblank rising edge, regardless of ce_pix
    // -----------------------------------------------------------------------
    logic             vblank_d;
    logic [CNT_W-1:0] scroll_x_act;
    logic [CNT_W-1:0] scroll_y_act;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vblank_d     <= 1'b0;
            scroll_x_act <= '0;
            scroll_y_act <= '0;
        end else begin
            vblank_d <= vblank;
            if (vblank && !vblank_d) begin
                scroll_x_act <= scroll_x;
                scroll_y_act <= scroll_y;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Coordinate arithmetic
    // The sum is taken directly at the map width: dropping the carry of a
    // wider sum and then truncating gives the same wrapped result.
    // -----------------------------------------------------------------------
    logic [SX_W-1:0]        sx;
    logic [SY_W-1:0]        sy;
    logic [CHAR_W_LOG2-1:0] bit_sel_c;

    always_comb begin
        sx        = SX_W'(hcnt) + SX_W'(scroll_x_act);
        sy        = SY_W'(vcnt) + SY_W'(scroll_y_act);
        // MSB of the glyph row is the leftmost pixel, so column 0 -> top bit.
        bit_sel_c = BIT_MSB - sx[CHAR_W_LOG2-1:0];
    end

    // -----------------------------------------------------------------------
    // Pipeline stages S0..S3
    // -----------------------------------------------------------------------
    logic [CHAR_W_LOG2-1:0] bit_sel_0;
    logic [CHAR_H_LOG2-1:0] gr_0;
    logic                   de_0;

    logic [7:0]             fg_1;
    logic [7:0]             bg_1;
    logic [CHAR_W_LOG2-1:0] bit_sel_1;
    logic                   de_1;

    logic                   char_a;
    logic                   a_2;
    logic                   de_2;

    always_comb begin
        char_a = chrom_data_out[bit_sel_1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chram_addr             <= '0;
            bit_sel_0              <= '0;
            gr_0                   <= '0;
            de_0                   <= 1'b0;
            chrom_addr             <= '0;
            fg_1                   <= '0;
            bg_1                   <= '0;
            bit_sel_1              <= '0;
            de_1                   <= 1'b0;
            charpaletteram_addr_rd <= '0;
            a_2                    <= 1'b0;
            de_2                   <= 1'b0;
        end else if (ce_pix) begin
            // S0: tile-map address and per-pixel glyph position
            chram_addr <= {sy[SY_W-1:CHAR_H_LOG2], sx[SX_W-1:CHAR_W_LOG2]};
            bit_sel_0  <= bit_sel_c;
            gr_0       <= sy[CHAR_H_LOG2-1:0];
            de_0       <= de;

            // S1: glyph-ROM address, colour indices captured
            chrom_addr <= {chmap_data_out, gr_0};
            fg_1       <= fgcolram_data_out;
            bg_1       <= bgcolram_data_out;
            bit_sel_1  <= bit_sel_0;
            de_1       <= de_0;

            // S2: pick foreground/background palette entry
            charpaletteram_addr_rd <= char_a ? fg_1 : bg_1;
            a_2                    <= char_a | (bg_1 != TRANSPARENT_BG);
            de_2                   <= de_1;
        end
    end

`ifdef CHARMAP_FADE_EN
    // -----------------------------------------------------------------------
    // S3 holds the palette colour and the fade level; S4 scales and drives
    // the outputs.
    // -----------------------------------------------------------------------
    logic [7:0] r_3;
    logic [7:0] g_3;
    logic [7:0] b_3;
    logic       a_3;
    logic       de_3;
    logic [3:0] fade_3;

    function automatic logic [7:0] fade_ch(input logic [7:0] c,
                                           input logic [3:0] f);
        logic [11:0] p;
        p = {4'b0000, c} * {8'h00, f};
        return (f == 4'hF) ? c : 8'(p >> 4);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_3    <= '0;
            g_3    <= '0;
            b_3    <= '0;
            a_3    <= 1'b0;
            de_3   <= 1'b0;
            fade_3 <= '0;
            r      <= '0;
            g      <= '0;
            b      <= '0;
            a      <= 1'b0;
            de_out <= 1'b0;
        end else if (ce_pix) begin
            r_3    <= charpaletteram_data_out[7:0];
            g_3    <= charpaletteram_data_out[15:8];
            b_3    <= charpaletteram_data_out[23:16];
            a_3    <= a_2;
            de_3   <= de_2;
            fade_3 <= fade;

            r      <= fade_ch(r_3, fade_3);
            g      <= fade_ch(g_3, fade_3);
            b      <= fade_ch(b_3, fade_3);
            a      <= a_3;
            de_out <= de_3;
        end
    end
`else
    // -----------------------------------------------------------------------
    // S3: palette colour straight to the outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r      <= '0;
            g      <= '0;
            b      <= '0;
            a      <= 1'b0;
            de_out <= 1'b0;
        end else if (ce_pix) begin
            r      <= charpaletteram_data_out[7:0];
            g      <= charpaletteram_data_out[15:8];
            b      <= charpaletteram_data_out[23:16];
            a      <= a_2;
            de_out <= de_2;
        end
    end
`endif

endmodule
